alu_ctrl_fsm: RTL

Multi-cycle control sequencer that drives the ALUop interface consumed by the ALU.
- Accepts one 32-bit RV32 R-type instruction via valid/ready handshake.
- Decodes it into the 4-bit ALU opcode and register-file addresses.
- Holds the opcode for the ALU's registered execute cycle, then issues register-file writeback of the ALU result.
- Sits between fetch/issue logic and the ALU/register-file datapath.

---
 rtl/alu_ctrl_pkg.sv | 48 ++++
 rtl/alu_ctrl_fsm_decode.sv | 80 ++++++++
 rtl/alu_ctrl_fsm.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU control sequencer: ALUop codes, RV32 opcode/funct fields, FSM states.
package alu_ctrl_pkg;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b1001;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_AND = 4'b0100;
    localparam logic [3:0] ALU_SLL = 4'b0101;
    localparam logic [3:0] ALU_SRL = 4'b1101;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DECODE = 2'b01,
        ST_EXEC   = 2'b10,
        ST_WB     = 2'b11
    } state_e;

    // ALU op implied by funct3 alone; NOP marks funct3 values this block never supports (SLT/SLTU).
    function automatic logic [3:0] base_op(input logic [2:0] funct3);
        logic [3:0] op;
        case (funct3)
            F3_ADD:  op = ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_XOR:  op = ALU_XOR;
            F3_SRL:  op = ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_ctrl_fsm_decode.sv
// Combinational RV32 decode into ALU op, legality, register indices and immediate.
// Immediate forms are decoded only when ALU_CTRL_IMM_OPS_EN is defined.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic [XLEN-1:0]  instr,
    output logic [3:0]       op,
    output logic             legal,
    output logic [XLEN-1:0]  imm,
    output logic             imm_sel,
    output logic [RF_AW-1:0] rs1,
    output logic [RF_AW-1:0] rs2,
    output logic [RF_AW-1:0] rd
);

    logic [6:0] opcode_s;
    logic [6:0] funct7_s;
    logic [2:0] funct3_s;
    logic [3:0] base_s;

    assign opcode_s = instr[6:0];
    assign funct3_s = instr[14:12];
    assign funct7_s = instr[31:25];
    assign base_s   = base_op(funct3_s);
    assign rd       = instr[7 +: RF_AW];
    assign rs1      = instr[15 +: RF_AW];
    assign rs2      = instr[20 +: RF_AW];

    // Opcode/funct classification; anything unmatched stays illegal with a NOP op.
    always_comb begin
        op      = ALU_NOP;
        legal   = 1'b0;
        imm     = '0;
        imm_sel = 1'b0;
        case (opcode_s)
            OP_R: begin
                if (funct7_s == F7_BASE && base_s != ALU_NOP) begin
                    op    = base_s;
                    legal = 1'b1;
                end else if (funct7_s == F7_ALT && funct3_s == F3_ADD) begin
                    op    = ALU_SUB;
                    legal = 1'b1;
                end else begin
                    op    = ALU_NOP;
                    legal = 1'b0;
                end
            end
`ifdef ALU_CTRL_IMM_OPS_EN
            OP_I: begin
                if (funct3_s == F3_SLL || funct3_s == F3_SRL) begin
                    if (funct7_s == F7_BASE) begin
                        op      = base_s;
                        legal   = 1'b1;
                        imm_sel = 1'b1;
                        imm     = {{(XLEN-5){1'b0}}, instr[24:20]};
                    end else begin
                        legal = 1'b0;
                    end
                end else if (base_s != ALU_NOP) begin
                    // funct3 000 is always ADDI: there is no SUBI encoding.
                    op      = base_s;
                    legal   = 1'b1;
                    imm_sel = 1'b1;
                    imm     = {{(XLEN-12){instr[31]}}, instr[31:20]};
                end else begin
                    legal = 1'b0;
                end
            end
`endif
            default: begin
                op    = ALU_NOP;
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Four-state IDLE/DECODE/EXEC/WB sequencer driving the ALU opcode and register-file ports.
// Optional immediate ALU ops are enabled with the ALU_CTRL_IMM_OPS_EN macro.
module alu_ctrl_fsm
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int RF_AW = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [XLEN-1:0]  instr,
    output logic [3:0]       alu_op,
    output logic [RF_AW-1:0] rf_raddr1,
    output logic [RF_AW-1:0] rf_raddr2,
    output logic [RF_AW-1:0] rf_waddr,
    output logic             rf_we,
    output logic             imm_sel,
    output logic [XLEN-1:0]  imm,
    output logic             done,
    output logic             illegal
);

    state_e           state_q,       state_d;
    logic [XLEN-1:0]  instr_q,       instr_d;
    logic             instr_ready_q, instr_ready_d;
    logic [3:0]       alu_op_q,      alu_op_d;
    logic [RF_AW-1:0] rf_raddr1_q,   rf_raddr1_d;
    logic [RF_AW-1:0] rf_raddr2_q,   rf_raddr2_d;
    logic [RF_AW-1:0] rd_q,          rd_d;
    logic [RF_AW-1:0] rf_waddr_q,    rf_waddr_d;
    logic             rf_we_q,       rf_we_d;
    logic             imm_sel_q,     imm_sel_d;
    logic [XLEN-1:0]  imm_q,         imm_d;
    logic             done_q,        done_d;
    logic             illegal_q,     illegal_d;

    logic [3:0]       dec_op_s;
    logic             dec_legal_s;
    logic [XLEN-1:0]  dec_imm_s;
    logic             dec_imm_sel_s;
    logic [RF_AW-1:0] dec_rs1_s;
    logic [RF_AW-1:0] dec_rs2_s;
    logic [RF_AW-1:0] dec_rd_s;

    alu_op_decode #(
        .XLEN  (XLEN),
        .RF_AW (RF_AW)
    ) u_decode (
        .instr   (instr_q),
        .op      (dec_op_s),
        .legal   (dec_legal_s),
        .imm     (dec_imm_s),
        .imm_sel (dec_imm_sel_s),
        .rs1     (dec_rs1_s),
        .rs2     (dec_rs2_s),
        .rd      (dec_rd_s)
    );

    // Next-state and next-output logic; pulsed outputs default low every cycle.
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_ready_d = instr_ready_q;
        alu_op_d      = ALU_NOP;
        rf_raddr1_d   = rf_raddr1_q;
        rf_raddr2_d   = rf_raddr2_q;
        rd_d          = rd_q;
        rf_waddr_d    = rf_waddr_q;
        rf_we_d       = 1'b0;
        imm_sel_d     = 1'b0;
        imm_d         = imm_q;
        done_d        = 1'b0;
        illegal_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid && instr_ready_q) begin
                    instr_d       = instr;
                    instr_ready_d = 1'b0;
                    state_d       = ST_DECODE;
                end else begin
                    instr_ready_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (dec_legal_s) begin
                    alu_op_d    = dec_op_s;
                    rf_raddr1_d = dec_rs1_s;
                    rf_raddr2_d = dec_rs2_s;
                    rd_d        = dec_rd_s;
                    imm_d       = dec_imm_s;
                    imm_sel_d   = dec_imm_sel_s;
                    state_d     = ST_EXEC;
                end else begin
                    illegal_d     = 1'b1;
                    instr_ready_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // x0 is hard-wired zero: retire without writing it.
                rf_waddr_d = rd_q;
                rf_we_d    = (rd_q != {RF_AW{1'b0}});
                done_d     = 1'b1;
                state_d    = ST_WB;
            end
            ST_WB: begin
                instr_ready_d = 1'b1;
                state_d       = ST_IDLE;
            end
            default: begin
                instr_ready_d = 1'b1;
                state_d       = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            instr_q       <= '0;
            instr_ready_q <= 1'b1;
            alu_op_q      <= ALU_NOP;
            rf_raddr1_q   <= '0;
            rf_raddr2_q   <= '0;
            rd_q          <= '0;
            rf_waddr_q    <= '0;
            rf_we_q       <= 1'b0;
            imm_sel_q     <= 1'b0;
            imm_q         <= '0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_ready_q <= instr_ready_d;
            alu_op_q      <= alu_op_d;
            rf_raddr1_q   <= rf_raddr1_d;
            rf_raddr2_q   <= rf_raddr2_d;
            rd_q          <= rd_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_we_q       <= rf_we_d;
            imm_sel_q     <= imm_sel_d;
            imm_q         <= imm_d;
            done_q        <= done_d;
            illegal_q     <= illegal_d;
        end
    end

    assign instr_ready = instr_ready_q;
    assign alu_op      = alu_op_q;
    assign rf_raddr1   = rf_raddr1_q;
    assign rf_raddr2   = rf_raddr2_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_we       = rf_we_q;
    assign imm_sel     = imm_sel_q;
    assign imm         = imm_q;
    assign done        = done_q;
    assign illegal     = illegal_q;

endmodule
